alu_exec: RTL and testbench

Single-issue execute unit that drives the team's 18-bit combinational ALU from the control side. It accepts instructions over a valid/ready handshake, reads operands from an internal 8-entry register file and presents them with the opcode to the ALU. It writes the ALU result back to the register file and queues it in a 2-entry output FIFO for downstream consumers. It sits between the instruction decoder and the ALU/trace path.

---
 rtl/alu_exec.sv | 152 +++++++++++++++
 tb/tb_alu_exec.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Single-issue execute unit: 8-entry register file, one execute slot feeding an
// external combinational ALU, and a 2-entry in-order result FIFO.
module alu_exec #(
    parameter int unsigned WORD_SIZE = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [2:0]           in_dst,
    input  logic [2:0]           in_src0,
    input  logic [2:0]           in_src1,
    input  logic                 in_imm_en,
    input  logic [WORD_SIZE-1:0] in_imm,
    output logic [WORD_SIZE-1:0] alu_r0,
    output logic [WORD_SIZE-1:0] alu_r1,
    output logic [3:0]           alu_op,
    input  logic [WORD_SIZE-1:0] alu_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_dst,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_zero,
    input  logic [2:0]           dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data
);

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned CNT_W    = 2;

    typedef struct packed {
        logic [IDX_W-1:0]     dst;
        logic [WORD_SIZE-1:0] data;
    } fifo_entry_t;

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];

    logic                 e_valid_q, e_valid_d;
    logic [OP_W-1:0]      e_op_q, e_op_d;
    logic [IDX_W-1:0]     e_dst_q, e_dst_d;
    logic [IDX_W-1:0]     e_src0_q, e_src0_d;
    logic [IDX_W-1:0]     e_src1_q, e_src1_d;
    logic                 e_imm_en_q, e_imm_en_d;
    logic [WORD_SIZE-1:0] e_imm_q, e_imm_d;

    fifo_entry_t          fifo_q [2];
    fifo_entry_t          fifo_d [2];
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 e_fire;
    logic                 accept;
    logic                 pop;
    logic [WORD_SIZE-1:0] rd0;
    logic [WORD_SIZE-1:0] rd1;
    fifo_entry_t          new_entry;

    // Handshake and ALU operand presentation; register 0 always reads as zero.
    always_comb begin
        e_fire    = e_valid_q && (count_q < CNT_W'(2));
        in_ready  = !e_valid_q || e_fire;
        accept    = in_valid && in_ready;
        pop       = (count_q != '0) && out_ready;
        rd0       = (e_src0_q == '0) ? '0 : regs_q[e_src0_q];
        rd1       = (e_src1_q == '0) ? '0 : regs_q[e_src1_q];
        alu_r0    = e_valid_q ? rd0 : '0;
        alu_r1    = e_valid_q ? (e_imm_en_q ? e_imm_q : rd1) : '0;
        alu_op    = e_valid_q ? e_op_q : '0;
        new_entry = '{dst: e_dst_q, data: alu_res};
        out_valid = (count_q != '0);
        out_dst   = fifo_q[0].dst;
        out_data  = fifo_q[0].data;
        out_zero  = (fifo_q[0].data == '0);
        dbg_data  = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
    end

    // Next state: writeback, execute slot load/drain, FIFO push/pop.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        e_valid_d  = e_valid_q;
        e_op_d     = e_op_q;
        e_dst_d    = e_dst_q;
        e_src0_d   = e_src0_q;
        e_src1_d   = e_src1_q;
        e_imm_en_d = e_imm_en_q;
        e_imm_d    = e_imm_q;
        fifo_d[0]  = fifo_q[0];
        fifo_d[1]  = fifo_q[1];
        count_d    = count_q;

        if (e_fire && (e_dst_q != '0)) regs_d[e_dst_q] = alu_res;

        if (accept) begin
            e_valid_d  = 1'b1;
            e_op_d     = in_op;
            e_dst_d    = in_dst;
            e_src0_d   = in_src0;
            e_src1_d   = in_src1;
            e_imm_en_d = in_imm_en;
            e_imm_d    = in_imm;
        end else if (e_fire) begin
            e_valid_d = 1'b0;
        end

        // Push and pop together only happens at count 1: new entry becomes head.
        case ({e_fire, pop})
            2'b10: begin
                if (count_q == '0) fifo_d[0] = new_entry;
                else               fifo_d[1] = new_entry;
                count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                fifo_d[0] = fifo_q[1];
                count_d   = count_q - CNT_W'(1);
            end
            2'b11: fifo_d[0] = new_entry;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            e_valid_q  <= 1'b0;
            e_op_q     <= '0;
            e_dst_q    <= '0;
            e_src0_q   <= '0;
            e_src1_q   <= '0;
            e_imm_en_q <= 1'b0;
            e_imm_q    <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            count_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            e_valid_q  <= e_valid_d;
            e_op_q     <= e_op_d;
            e_dst_q    <= e_dst_d;
            e_src0_q   <= e_src0_d;
            e_src1_q   <= e_src1_d;
            e_imm_en_q <= e_imm_en_d;
            e_imm_q    <= e_imm_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with a small reference ALU closing the loop on alu_res.
module tb_alu_exec;

    localparam int unsigned W = 18;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [2:0]   in_dst, in_src0, in_src1;
    logic         in_imm_en;
    logic [W-1:0] in_imm;
    logic [W-1:0] alu_r0, alu_r1, alu_res;
    logic [3:0]   alu_op;
    logic         out_valid, out_ready;
    logic [2:0]   out_dst;
    logic [W-1:0] out_data;
    logic         out_zero;
    logic [2:0]   dbg_addr;
    logic [W-1:0] dbg_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [21:0] got_q [$];
    logic [21:0] exp_q [$];
    int          pop_cyc_q [$];

    alu_exec #(.WORD_SIZE(W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_src0(in_src0), .in_src1(in_src1),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .alu_r0(alu_r0), .alu_r1(alu_r1), .alu_op(alu_op), .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_dst(out_dst),
        .out_data(out_data), .out_zero(out_zero),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference ALU: 0 r0, 1 r1, 2 add, 3 sub, 4 and, 5 or, 6 xor, 7 not r1, else 0.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0: alu_res = alu_r0;
            4'd1: alu_res = alu_r1;
            4'd2: alu_res = alu_r0 + alu_r1;
            4'd3: alu_res = alu_r0 - alu_r1;
            4'd4: alu_res = alu_r0 & alu_r1;
            4'd5: alu_res = alu_r0 | alu_r1;
            4'd6: alu_res = alu_r0 ^ alu_r1;
            4'd7: alu_res = ~alu_r1;
            default: alu_res = '0;
        endcase
    end

    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            got_q.push_back({out_zero, out_dst, out_data});
            pop_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_dbg(input logic [2:0] idx, input logic [W-1:0] exp);
        dbg_addr = idx;
        #1;
        check($sformatf("dbg_r%0d", idx), 32'(dbg_data), 32'(exp));
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] s0,
                         input logic [2:0] s1, input logic ie, input logic [W-1:0] imm);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_dst = dst; in_src0 = s0; in_src1 = s1;
        in_imm_en = ie; in_imm = imm;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [21:0] ent(input logic [2:0] dst, input logic [W-1:0] data);
        return {(data == '0), dst, data};
    endfunction

    task automatic check_pops(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 50) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        pop_cyc_q.delete();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_dst = '0; in_src0 = '0;
        in_src1 = '0; in_imm_en = 1'b0; in_imm = '0; out_ready = 1'b0; dbg_addr = '0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_dst", 32'(out_dst), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd1);
        check("rst_alu_r0", 32'(alu_r0), 32'd0);
        check("rst_alu_r1", 32'(alu_r1), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 8; i++) check_dbg(3'(i), '0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;

        // Load and add with 18-bit wrap
        issue(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 18'h00005);
        issue(4'd1, 3'd2, 3'd0, 3'd0, 1'b1, 18'h3FFFF);
        issue(4'd2, 3'd3, 3'd1, 3'd2, 1'b0, 18'h0);
        exp_q.push_back(ent(3'd1, 18'h00005));
        exp_q.push_back(ent(3'd2, 18'h3FFFF));
        exp_q.push_back(ent(3'd3, 18'h00004));
        check_pops("add");
        check_dbg(3'd3, 18'h00004);

        // Register 0: result still queued, nothing written; also check E latency
        out_ready = 1'b0;
        issue(4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 18'h12345);
        @(negedge clock);
        check("r0_out_valid_early", 32'(out_valid), 32'd0);
        check("r0_alu_r1", 32'(alu_r1), 32'h12345);
        check("r0_alu_op", 32'(alu_op), 32'd1);
        @(negedge clock);
        check("r0_out_valid", 32'(out_valid), 32'd1);
        check("r0_out_dst", 32'(out_dst), 32'd0);
        check("r0_out_data", 32'(out_data), 32'h12345);
        check("r0_out_zero", 32'(out_zero), 32'd0);
        check_dbg(3'd0, '0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(ent(3'd0, 18'h12345));
        check_pops("r0");

        // Backpressure: two results fill the FIFO, the third stalls in E
        out_ready = 1'b0;
        issue(4'd1, 3'd4, 3'd0, 3'd0, 1'b1, 18'h00011);
        issue(4'd1, 3'd5, 3'd0, 3'd0, 1'b1, 18'h00022);
        issue(4'd1, 3'd6, 3'd0, 3'd0, 1'b1, 18'h00033);
        in_valid = 1'b1; in_op = 4'd1; in_dst = 3'd7; in_src0 = '0; in_src1 = '0;
        in_imm_en = 1'b1; in_imm = 18'h00044;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'h00011);
            check("bp_out_dst", 32'(out_dst), 32'd4);
            check("bp_alu_r1", 32'(alu_r1), 32'h00033);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_ready_before_pop", 32'(in_ready), 32'd0);
        @(negedge clock);
        check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(ent(3'd4, 18'h00011));
        exp_q.push_back(ent(3'd5, 18'h00022));
        exp_q.push_back(ent(3'd6, 18'h00033));
        exp_q.push_back(ent(3'd7, 18'h00044));
        check_pops("bp");

        // Dependency chain at one result per clock
        issue(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 18'h00001);
        for (int k = 0; k < 5; k++) issue(4'd2, 3'd1, 3'd1, 3'd1, 1'b0, 18'h0);
        exp_q.push_back(ent(3'd1, 18'd1));
        exp_q.push_back(ent(3'd1, 18'd2));
        exp_q.push_back(ent(3'd1, 18'd4));
        exp_q.push_back(ent(3'd1, 18'd8));
        exp_q.push_back(ent(3'd1, 18'd16));
        exp_q.push_back(ent(3'd1, 18'd32));
        repeat (4) @(negedge clock);
        if (pop_cyc_q.size() == 6) check("chain_span", 32'(pop_cyc_q[5] - pop_cyc_q[0]), 32'd5);
        else check("chain_pops", 32'(pop_cyc_q.size()), 32'd6);
        @(posedge clock);
        #1;
        check_pops("chain");

        // Opcodes: not, sub of equal operands, unused opcode
        issue(4'd7, 3'd4, 3'd0, 3'd0, 1'b1, 18'h00000);
        issue(4'd3, 3'd5, 3'd1, 3'd1, 1'b0, 18'h0);
        issue(4'd12, 3'd6, 3'd1, 3'd0, 1'b1, 18'h00005);
        exp_q.push_back({1'b0, 3'd4, 18'h3FFFF});
        exp_q.push_back({1'b1, 3'd5, 18'h00000});
        exp_q.push_back({1'b1, 3'd6, 18'h00000});
        check_pops("ops");
        check_dbg(3'd4, 18'h3FFFF);
        check_dbg(3'd6, 18'h00000);

        // Reset with E valid and one FIFO entry
        out_ready = 1'b0;
        issue(4'd1, 3'd2, 3'd0, 3'd0, 1'b1, 18'h00077);
        issue(4'd1, 3'd3, 3'd0, 3'd0, 1'b1, 18'h00088);
        check("mid_out_valid_pre", 32'(out_valid), 32'd1);
        check("mid_alu_r1_pre", 32'(alu_r1), 32'h00088);
        #1;
        reset = 1'b1;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_alu_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 8; i++) check_dbg(3'(i), '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("post_out_valid", 32'(out_valid), 32'd0);
        check_dbg(3'd3, '0);
        check_dbg(3'd2, '0);
        check("post_pops", 32'(got_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
